// File: rtl/dac_wr_arb.sv
// Purpose: round-robin arbiter serialising two requesters onto one parallel DAC write port.
// Latency: grant on the sampling edge; ack in the last HOLD cycle, SETUP+WR_LOW+HOLD cycles after grant.
// Backpressure: a requester holds req until its ack; losers and later requests wait in IDLE.
module dac_wr_arb #(
  parameter int SETUP_CYC  = 2,
  parameter int WR_LOW_CYC = 3,
  parameter int HOLD_CYC   = 2,
  parameter int SKIP_DUP   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       da1_wr,
  output logic [1:0] da1_a,
  output logic [7:0] da1_din
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Phase counter counts down from (phase length - 1) to zero.
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] WR_LAST    = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

  state_t     state;
  logic [3:0] phase;
  logic       gnt_id;     // requester owning the current transaction
  logic       last_id;    // requester served most recently
  logic [7:0] shadow [4];
  logic [3:0] shadow_vld;

  logic       pick;
  logic [1:0] pick_addr;
  logic [7:0] pick_data;
  logic       grant_ok;
  logic       dup;

  assign busy = (state != IDLE);

  // Arbitration: round-robin when both request, otherwise whoever asks.
  // Grants are withheld while an ack is on the wires: after a skipped
  // write the requester still holds req in that cycle, and sampling it
  // would replay the request it is about to drop.
  always_comb begin
    pick      = 1'b0;
    pick_addr = addr0;
    pick_data = data0;
    dup       = 1'b0;
    grant_ok  = 1'b0;
    if (req0 && req1) begin
      pick = ~last_id;
    end else begin
      pick = req1;
    end
    if (pick) begin
      pick_addr = addr1;
      pick_data = data1;
    end
    dup      = (SKIP_DUP != 0) && shadow_vld[pick_addr] && (shadow[pick_addr] == pick_data);
    grant_ok = (state == IDLE) && (req0 || req1) && !ack0 && !ack1;
  end

  // Write sequencer: grant, SETUP -> STROBE -> HOLD with registered strobe and acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 4'd0;
      gnt_id     <= 1'b0;
      last_id    <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      da1_wr     <= 1'b1;
      da1_a      <= 2'd0;
      da1_din    <= 8'h00;
      shadow_vld <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            last_id <= pick;
            gnt_id  <= pick;
            if (dup) begin
              // Channel already holds this code: acknowledge without a bus cycle.
              ack0 <= ~pick;
              ack1 <= pick;
            end else begin
              da1_a   <= pick_addr;
              da1_din <= pick_data;
              state   <= SETUP;
              phase   <= SETUP_LAST;
            end
          end
        end
        SETUP: begin
          if (phase == 4'd0) begin
            state              <= STROBE;
            phase              <= WR_LAST;
            da1_wr             <= 1'b0;
            shadow[da1_a]      <= da1_din;
            shadow_vld[da1_a]  <= 1'b1;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        STROBE: begin
          if (phase == 4'd0) begin
            state  <= HOLD;
            phase  <= HOLD_LAST;
            da1_wr <= 1'b1;
            if (HOLD_LAST == 4'd0) begin
              ack0 <= ~gnt_id;
              ack1 <= gnt_id;
            end
          end else begin
            phase <= phase - 4'd1;
          end
        end
        HOLD: begin
          if (phase == 4'd0) begin
            state <= IDLE;
          end else begin
            phase <= phase - 4'd1;
            if (phase == 4'd1) begin
              ack0 <= ~gnt_id;
              ack1 <= gnt_id;
            end
          end
        end
        default: begin
          state  <= IDLE;
          da1_wr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wr_arb.sv
// Purpose: directed checks of dac_wr_arb timing, arbitration, duplicate skip and reset abort.
// Latency: cycle numbers count from the cycle in which the first request is presented.
// Backpressure: the bench models requesters that drop req the cycle after their ack.
module tb_dac_wr_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] addr0 = 2'd0;
  logic [1:0] addr1 = 2'd0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;

  logic       ack0, ack1, busy, da1_wr;
  logic [1:0] da1_a;
  logic [7:0] da1_din;

  logic       s_ack0, s_ack1, s_busy, s_wr;
  logic [1:0] s_a;
  logic [7:0] s_din;

  int errors = 0;
  int checks = 0;

  int a0c, a1c, both, g0, g1, rep;
  logic d0, d1;
  int ack_q[$];

  always #5 clk = ~clk;

  dac_wr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .da1_wr(da1_wr), .da1_a(da1_a), .da1_din(da1_din)
  );

  dac_wr_arb #(.SKIP_DUP(1)) dut_sk (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ack0(s_ack0), .ack1(s_ack1), .busy(s_busy),
    .da1_wr(s_wr), .da1_a(s_a), .da1_din(s_din)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0, reset released, requests idle.
  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values.
    tick();
    chk("rst_wr",   32'(da1_wr),  32'd1);
    chk("rst_a",    32'(da1_a),   32'd0);
    chk("rst_din",  32'(da1_din), 32'h00);
    chk("rst_ack0", 32'(ack0),    32'd0);
    chk("rst_ack1", 32'(ack1),    32'd0);
    chk("rst_busy", 32'(busy),    32'd0);

    // Basic write timing with default parameters.
    do_reset();
    addr0 = 2'd2; data0 = 8'h5A; req0 = 1'b1;
    tick();
    chk("w_a_c1",    32'(da1_a),   32'd2);
    chk("w_din_c1",  32'(da1_din), 32'h5A);
    chk("w_wr_c1",   32'(da1_wr),  32'd1);
    chk("w_busy_c1", 32'(busy),    32'd1);
    tick();
    chk("w_wr_c2", 32'(da1_wr), 32'd1);
    tick();
    chk("w_wr_c3", 32'(da1_wr), 32'd0);
    tick();
    chk("w_wr_c4", 32'(da1_wr), 32'd0);
    tick();
    chk("w_wr_c5",   32'(da1_wr), 32'd0);
    chk("w_ack0_c5", 32'(ack0),   32'd0);
    tick();
    chk("w_wr_c6",   32'(da1_wr), 32'd1);
    chk("w_ack0_c6", 32'(ack0),   32'd0);
    tick();
    chk("w_ack0_c7", 32'(ack0),   32'd1);
    chk("w_ack1_c7", 32'(ack1),   32'd0);
    chk("w_wr_c7",   32'(da1_wr), 32'd1);
    chk("w_busy_c7", 32'(busy),   32'd1);
    tick();
    req0 = 1'b0;
    chk("w_busy_c8", 32'(busy),    32'd0);
    chk("w_ack0_c8", 32'(ack0),    32'd0);
    chk("w_din_c8",  32'(da1_din), 32'h5A);

    // Both requesting from reset, each drops after its ack.
    do_reset();
    addr0 = 2'd0; data0 = 8'h11; addr1 = 2'd3; data1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    a0c = 0; a1c = 0; both = 0; g0 = -1; g1 = -1; d0 = 1'b0; d1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
      d0 = ack0;
      d1 = ack1;
      if (ack0) a0c++;
      if (ack1) a1c++;
      if (ack0 && ack1) both++;
      if (g0 < 0 && busy && da1_a == 2'd0) g0 = c;
      if (g1 < 0 && busy && da1_a == 2'd3) g1 = c;
    end
    chk("rr_first_req0",  32'(g0),   32'd1);
    chk("rr_req1_grant",  32'(g1),   32'd9);
    chk("rr_ack0_count",  32'(a0c),  32'd1);
    chk("rr_ack1_count",  32'(a1c),  32'd1);
    chk("rr_ack_overlap", 32'(both), 32'd0);
    chk("rr_idle_end",    32'(busy), 32'd0);

    // Both held continuously: grants must alternate.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    both = 0;
    ack_q.delete();
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (ack0) ack_q.push_back(0);
      if (ack1) ack_q.push_back(1);
      if (ack0 && ack1) both++;
    end
    req0 = 1'b0; req1 = 1'b0;
    rep = 0;
    for (int i = 1; i < ack_q.size(); i++) begin
      if (ack_q[i] == ack_q[i-1]) rep++;
    end
    chk("alt_count",   32'(ack_q.size()), 32'd4);
    chk("alt_0",       32'(ack_q[0]),     32'd0);
    chk("alt_1",       32'(ack_q[1]),     32'd1);
    chk("alt_2",       32'(ack_q[2]),     32'd0);
    chk("alt_3",       32'(ack_q[3]),     32'd1);
    chk("alt_repeat",  32'(rep),          32'd0);
    chk("alt_overlap", 32'(both),         32'd0);

    // Duplicate skip on the SKIP_DUP instance.
    do_reset();
    addr1 = 2'd1; data1 = 8'h33; req1 = 1'b1;
    repeat (7) tick();
    chk("sk_first_ack", 32'(s_ack1), 32'd1);
    tick();
    req1 = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    chk("sk_dup_ack",  32'(s_ack1), 32'd1);
    chk("sk_dup_ack0", 32'(s_ack0), 32'd0);
    chk("sk_dup_busy", 32'(s_busy), 32'd0);
    chk("sk_dup_wr",   32'(s_wr),   32'd1);
    chk("sk_dup_din",  32'(s_din),  32'h33);
    tick();
    req1 = 1'b0;
    chk("sk_no_replay", 32'(s_ack1), 32'd0);
    chk("sk_idle_busy", 32'(s_busy), 32'd0);
    chk("sk_idle_wr",   32'(s_wr),   32'd1);
    tick();
    data1 = 8'h34; req1 = 1'b1;
    tick();
    chk("sk_new_busy", 32'(s_busy), 32'd1);
    chk("sk_new_din",  32'(s_din),  32'h34);
    chk("sk_new_a",    32'(s_a),    32'd1);
    tick();
    tick();
    chk("sk_new_strobe", 32'(s_wr), 32'd0);
    repeat (4) tick();
    chk("sk_new_ack", 32'(s_ack1), 32'd1);
    tick();
    req1 = 1'b0;

    // Reset asserted in the second STROBE cycle.
    do_reset();
    addr0 = 2'd2; data0 = 8'h5A; req0 = 1'b1;
    repeat (4) tick();
    chk("ra_pre_wr", 32'(da1_wr), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_wr",   32'(da1_wr), 32'd1);
    chk("ra_busy", 32'(busy),   32'd0);
    chk("ra_ack0", 32'(ack0),   32'd0);
    chk("ra_a",    32'(da1_a),  32'd0);
    req0 = 1'b0;
    tick();
    tick();
    chk("ra_hold_ack0", 32'(ack0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ra_no_pending", 32'(busy), 32'd0);
    chk("ra_no_ack",     32'(ack0), 32'd0);
    addr0 = 2'd1; data0 = 8'h77; req0 = 1'b1;
    repeat (7) tick();
    chk("ra_new_ack", 32'(ack0),    32'd1);
    chk("ra_new_a",   32'(da1_a),   32'd1);
    chk("ra_new_din", 32'(da1_din), 32'h77);
    tick();
    req0 = 1'b0;

    // Requester data changing after grant has no effect.
    do_reset();
    addr0 = 2'd0; data0 = 8'h10; req0 = 1'b1;
    tick();
    data0 = 8'hFF;
    chk("hold_din_c1", 32'(da1_din), 32'h10);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk($sformatf("hold_din_c%0d", k), 32'(da1_din), 32'h10);
    end
    chk("hold_ack_c7", 32'(ack0), 32'd1);
    tick();
    req0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_wr_arb.md
DAC_WR_ARB -- requirements
Module: dac_wr_arb

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles with address and data valid and da1_wr high before the strobe (legal range 1..15).
REQ-002 SHALL have parameter WR_LOW_CYC, default 3, cycles da1_wr is held low (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles with address and data held and da1_wr high after the strobe (legal range 1..15).
REQ-004 SHALL have parameter SKIP_DUP, default 0; 1 suppresses a DAC write whose data equals the last value written to that channel.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports req0 and req1, input, 1 bit each: write requests (req0 is the timing-generator path, req1 is the level-configuration path).
REQ-008 SHALL have ports addr0 and addr1, input, 2 bits each: DAC channel for each requester.
REQ-009 SHALL have ports data0 and data1, input, 8 bits each: DAC code for each requester.
REQ-010 SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle completion pulse to the matching requester.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port da1_wr, output, 1 bit: DAC write strobe, active low.
REQ-013 SHALL have port da1_a, output, 2 bits: DAC channel select.
REQ-014 SHALL have port da1_din, output, 8 bits: DAC data bus.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, STROBE and HOLD, with a 4-bit phase counter.
REQ-016 In IDLE, a request sampled high SHALL be granted on that edge: grant id, addr and data are latched into da1_a, da1_din and an internal grant register, and the FSM enters SETUP on the next cycle.
REQ-017 Arbitration SHALL be round-robin: when req0 and req1 are both high in IDLE, the requester not served last is granted, and after reset req0 is treated as "not last served".
REQ-018 SETUP SHALL last SETUP_CYC cycles with da1_wr=1, then move to STROBE.
REQ-019 STROBE SHALL last WR_LOW_CYC cycles with da1_wr=0, then move to HOLD.
REQ-020 HOLD SHALL last HOLD_CYC cycles with da1_wr=1; ack of the granted requester pulses high in the last HOLD cycle; the FSM then returns to IDLE.
REQ-021 da1_a and da1_din SHALL remain constant from the first SETUP cycle through the last HOLD cycle, and SHALL retain their last values in IDLE.
REQ-022 Requester inputs SHALL NOT be sampled after the grant; changes to them during a transaction SHALL have no effect on it.
REQ-023 A requester SHALL drop req in the cycle after it sees ack; req still high in IDLE after an ack SHALL start a new transaction.
REQ-024 The minimum spacing between grants SHALL be SETUP_CYC+WR_LOW_CYC+HOLD_CYC+1 cycles, with one mandatory IDLE cycle between transactions.
REQ-025 The block SHALL keep a 4-entry shadow of the last code written per channel, each entry with a valid bit; the entry is updated on entry to STROBE.
REQ-026 If SKIP_DUP=1 and the granted channel's shadow entry is valid and equal to the granted data, the FSM SHALL stay in IDLE, drive no strobe, leave da1_a and da1_din unchanged, and pulse the matching ack on the cycle after the grant.
REQ-027 A skipped grant SHALL update the round-robin pointer exactly as a full write does.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.
REQ-029 da1_wr SHALL never be low outside STROBE.

Reset
REQ-030 While rst_n=0, outputs SHALL be: da1_wr=1, da1_a=0, da1_din=0x00, ack0=0, ack1=0, busy=0; the state SHALL be IDLE, the round-robin pointer SHALL favour req0, and all shadow valid bits SHALL be cleared.
REQ-031 Reset asserted mid-transaction, including during STROBE, SHALL force da1_wr high immediately (asynchronously), abort without any ack, and leave no pending grant after release.
REQ-032 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge after release.

Verification
REQ-033 Defaults; req0=1, addr0=2, data0=0x5A sampled at cycle 0 -> da1_a=2 and da1_din=0x5A from cycle 1; da1_wr=1 in cycles 1-2, 0 in cycles 3-5, 1 in cycles 6-7; ack0 pulses in cycle 7; busy=0 in cycle 8.
REQ-034 req0 and req1 both high from reset, each dropped after its ack -> req0 is served first, req1 is granted 8 cycles later in the mandatory IDLE cycle, and there is exactly one ack per requester.
REQ-035 req0 and req1 held high continuously -> grants alternate 0,1,0,1 and no requester receives two consecutive acks.
REQ-036 SKIP_DUP=1; write channel 1 = 0x33, then write channel 1 = 0x33 again -> the second request produces ack one cycle after grant with da1_wr held at 1; a subsequent write of 0x34 performs a full strobe.
REQ-037 rst_n pulled low in the second STROBE cycle -> da1_wr=1 within the same cycle, no ack issued, busy=0; after release a new req0 completes normally.
REQ-038 data0 changed from 0x10 to 0xFF during SETUP -> da1_din stays 0x10 through the end of HOLD.
